// File: rtl/dmem_responder_if.sv
// Request/response handshake between the MEM stage (master) and the
// multi-cycle data-memory responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data memory with byte/half/word lanes and WAIT_STATES wait cycles.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning them.
//
// state  | meaning
// S_IDLE | req_ready high, waiting for a request
// S_WAIT | down-counting wait states; access happens when the counter is 0
// S_RESP | rsp_valid high, holding the response until rsp_ready
module dmem_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              reset,
   dmem_responder_if.slave   bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic                    req_ready_q;
   logic                    rsp_valid_q;
   logic [31:0]             rsp_rdata_q;
   logic                    rsp_err_q;

   logic                    lat_we;
   logic [2:0]              lat_funct3;
   logic [ADDR_WIDTH+1:0]   lat_addr;
   logic [31:0]             lat_wdata;

   logic [31:0]             mem [DEPTH];

   logic                    is_half;
   logic                    is_word;
   logic                    bad_funct3;
   logic                    acc_err;
   logic [1:0]              lane;
   logic [ADDR_WIDTH-1:0]   widx;
   logic [31:0]             rd_word;
   logic [7:0]              byte_sel;
   logic [15:0]             half_sel;
   logic [31:0]             ld_data;
   logic [3:0]              wmask;
   logic [31:0]             wword;
   logic                    access;
   logic                    mem_wr;

   // ---------------------------------------------------------------
   // Access decode, all from the latched request
   // ---------------------------------------------------------------
   assign is_half    = (lat_funct3[1:0] == 2'b01);
   assign is_word    = (lat_funct3[1:0] == 2'b10);
   assign bad_funct3 = (lat_funct3[1:0] == 2'b11) ||
                       (lat_funct3[2] && (lat_we || is_word));

`ifdef DMEM_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = (is_half && lat_addr[0]) ||
                       (is_word && (lat_addr[1:0] != 2'b00));
   assign acc_err    = bad_funct3 || misaligned;
`else
   assign acc_err    = bad_funct3;
`endif

   // Natural alignment of the lane; with trapping enabled a misaligned
   // request never reaches the memory, so forcing alignment is harmless.
   assign lane = is_word ? 2'b00 :
                 is_half ? {lat_addr[1], 1'b0} :
                           lat_addr[1:0];

   assign widx    = lat_addr[ADDR_WIDTH+1:2];
   assign rd_word = mem[widx];

   assign byte_sel = rd_word[{lane, 3'b000} +: 8];
   assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      ld_data = 32'd0;
      if (!acc_err && !lat_we) begin
         case (lat_funct3)
            3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'd0, byte_sel};
            3'b101:  ld_data = {16'd0, half_sel};
            default: ld_data = 32'd0;
         endcase
      end
   end

   always_comb begin
      wmask = 4'b0000;
      wword = lat_wdata;
      case (lat_funct3[1:0])
         2'b00: begin
            wmask = 4'b0001 << lane;
            wword = {4{lat_wdata[7:0]}};
         end
         2'b01: begin
            wmask = 4'b0011 << lane;
            wword = {2{lat_wdata[15:0]}};
         end
         2'b10: begin
            wmask = 4'b1111;
            wword = lat_wdata;
         end
         default: begin
            wmask = 4'b0000;
            wword = lat_wdata;
         end
      endcase
   end

   assign access = (state == S_WAIT) && (cnt == '0);
   assign mem_wr = access && lat_we && !acc_err;

   // Memory is deliberately outside the reset domain: contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask[b]) mem[widx][b*8 +: 8] <= wword[b*8 +: 8];
         end
      end
   end

   // ---------------------------------------------------------------
   // Handshake FSM with registered outputs
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
         lat_we      <= 1'b0;
         lat_funct3  <= 3'b000;
         lat_addr    <= '0;
         lat_wdata   <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  lat_we      <= bus.req_we;
                  lat_funct3  <= bus.req_funct3;
                  lat_addr    <= bus.req_addr[ADDR_WIDTH+1:0];
                  lat_wdata   <= bus.req_wdata;
                  cnt         <= CNT_W'(WAIT_STATES);
                  req_ready_q <= 1'b0;
                  state       <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_rdata_q <= ld_data;
                  rsp_err_q   <= acc_err;
                  rsp_valid_q <= 1'b1;
                  state       <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: begin
               state       <= S_IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a byte-level memory model.
module tb_dmem_responder;

   localparam int ADDR_WIDTH  = 8;
   localparam int WAIT_STATES = 2;
   localparam int DEPTH       = 2 ** ADDR_WIDTH;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   logic [31:0] ref_mem [DEPTH];

   dmem_responder_if bus ();

   dmem_responder #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .WAIT_STATES (WAIT_STATES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference: size/sign from funct3, byte-granular memory updates.
   function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr_in,
                                 input logic [31:0] wd, output logic [31:0] rd, output bit err);
      int          size;
      bit          uns;
      bit          bad;
      int          wi;
      int          off;
      logic [31:0] addr;
      logic [31:0] val;
      size = 0; uns = 0; bad = 0; rd = 32'd0; err = 0; addr = addr_in;
      case (f3)
         3'd0: size = 1;
         3'd1: size = 2;
         3'd2: size = 4;
         3'd4: begin size = 1; uns = 1; end
         3'd5: begin size = 2; uns = 1; end
         default: bad = 1;
      endcase
      if (we && uns) bad = 1;
      if (!bad && (addr % size) != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
         bad = 1;
`else
         addr = addr - (addr % size);
`endif
      end
      if (bad) begin
         err = 1;
         return;
      end
      wi  = int'((addr / 4) % DEPTH);
      off = int'(addr % 4);
      if (we) begin
         for (int i = 0; i < size; i++) ref_mem[wi][(off+i)*8 +: 8] = wd[i*8 +: 8];
      end else begin
         val = 32'd0;
         for (int i = 0; i < size; i++) val = val | (32'(ref_mem[wi][(off+i)*8 +: 8]) << (8*i));
         if (!uns && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
         if (!uns && size == 2 && val[15]) val = val | 32'hFFFF_0000;
         rd = val;
      end
   endfunction

   // One full transaction; assumes entry just after a rising edge in IDLE.
   task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold, input bit keep_valid,
                      output logic [31:0] got_rd, output logic got_err);
      logic [31:0] exp_rd;
      bit          exp_err;
      int          n;
      model(we, f3, addr, wd, exp_rd, exp_err);
      check("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      bus.rsp_ready  = (hold == 0);
      @(posedge clk); #1;
      bus.req_valid  = keep_valid;
      bus.req_wdata  = $urandom;
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 32'(n), 32'(WAIT_STATES + 1));
      got_rd  = bus.rsp_rdata;
      got_err = bus.rsp_err;
      check("rdata", got_rd, exp_rd);
      check("err", 32'(got_err), 32'(exp_err));
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(bus.rsp_valid), 32'd1);
         check("hold_rdata", bus.rsp_rdata, exp_rd);
         check("hold_err", 32'(bus.rsp_err), 32'(exp_err));
         check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("rsp_valid_clr", 32'(bus.rsp_valid), 32'd0);
      check("req_ready_back", 32'(bus.req_ready), 32'd1);
      bus.rsp_ready = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;
   logic [2:0]  f3_tab [8];

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset = 1'b0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
      bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b0;
      f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2; f3_tab[3] = 3'd4;
      f3_tab[4] = 3'd5; f3_tab[5] = 3'd3; f3_tab[6] = 3'd6; f3_tab[7] = 3'd7;

      #1 reset = 1'b1;
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rdata", bus.rsp_rdata, 32'd0);
      check("rst_err", 32'(bus.rsp_err), 32'd0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      // fill every word so all later loads have a known expectation
      for (int i = 0; i < DEPTH; i++)
         txn(1'b1, 3'd2, {($urandom_range(0, 3) << 10) | (i << 2)}, $urandom, 0, 1'b0, rd, er);

      // 1: word store/load
      txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, er);
      txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, rd, er);
      check("t1_lw", rd, 32'hDEADBEEF);
      check("t1_err", 32'(er), 32'd0);

      // 2: byte store, signed/unsigned byte loads
      txn(1'b1, 3'd0, 32'h13, 32'h80, 0, 1'b0, rd, er);
      txn(1'b0, 3'd0, 32'h13, 32'h0, 0, 1'b0, rd, er);
      check("t2_lb", rd, 32'hFFFFFF80);
      txn(1'b0, 3'd4, 32'h13, 32'h0, 0, 1'b0, rd, er);
      check("t2_lbu", rd, 32'h00000080);
      txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, rd, er);
      check("t2_lw", rd, 32'h80ADBEEF);

      // 3: misaligned halfword store
      txn(1'b1, 3'd1, 32'h11, 32'h1234, 0, 1'b0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
      check("t3_sh_err", 32'(er), 32'd1);
      txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, rd, er);
      check("t3_lw", rd, 32'h80ADBEEF);
`else
      check("t3_sh_err", 32'(er), 32'd0);
      txn(1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, rd, er);
      check("t3_lw", rd, 32'h80AD1234);
`endif

      // 4: backpressure with req_valid held
      txn(1'b0, 3'd5, 32'h12, 32'h0, 5, 1'b1, rd, er);

      // 5: reset during WAIT drops the store
      txn(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0, rd, er);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
      bus.req_addr = 32'h20; bus.req_wdata = 32'h5555AAAA; bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("t5_rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("t5_rst_rdata", bus.rsp_rdata, 32'd0);
      @(negedge clk) reset = 1'b0;
      bus.rsp_ready = 1'b0;
      @(posedge clk); #1;
      txn(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0, rd, er);
      check("t5_lw_prior", rd, ref_mem[8]);

      // 6: wrap-around and invalid funct3
      txn(1'b1, 3'd2, 32'h400, 32'h0BADF00D, 0, 1'b0, rd, er);
      txn(1'b0, 3'd2, 32'h000, 32'h0, 0, 1'b0, rd, er);
      check("t6_wrap", rd, 32'h0BADF00D);
      txn(1'b0, 3'd3, 32'h004, 32'h0, 0, 1'b0, rd, er);
      check("t6_bad_err", 32'(er), 32'd1);
      check("t6_bad_rdata", rd, 32'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         txn(1'($urandom_range(0, 1)),
             f3_tab[($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7)],
             $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd, er);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
